// File: rtl/adc_seq_if.sv
// Capture-engine handshake and host read port of the ADC sequencer.
// slave = sequencer side, master = capture engine / host side.
interface adc_seq_if;
  logic       conv_start;
  logic       sample_valid;
  logic [7:0] sample;
  logic       rd_req;
  logic       rd_ack;
  logic [7:0] rd_data;

  modport master (input conv_start, rd_ack, rd_data,
                  output sample_valid, sample, rd_req);
  modport slave  (output conv_start, rd_ack, rd_data,
                  input sample_valid, sample, rd_req);
endinterface

// File: rtl/adc_seq_ctrl.sv
// ADC conversion sequencer: paced conversion requests, 2^n sample averaging,
// 16-entry result FIFO with host read port and sticky overflow/timeout flags.
module adc_seq_ctrl (
  input  logic       adc_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] period,
  input  logic [1:0] avg_sel,
  input  logic       clr_flags,
  adc_seq_if.slave   bus,
  output logic [4:0] count,
  output logic       overflow,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, WAIT, START, CONV, STORE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  avg_q, avg_d;
  logic [10:0] acc_q, acc_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [5:0]  tmo_q, tmo_d;
  logic        to_set;

  logic [7:0]  mem [16];
  logic [3:0]  wptr, rptr;
  logic [7:0]  result;
  logic        do_rd, do_wr, ov_set;

  assign bus.conv_start = (state_q == START);

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      avg_q   <= '0;
      acc_q   <= '0;
      scnt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      avg_q   <= avg_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    avg_d   = avg_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    tmo_d   = tmo_q;
    to_set  = 1'b0;
    unique case (state_q)
      IDLE: if (enable) begin
        avg_d  = avg_sel;
        acc_d  = '0;
        scnt_d = '0;
        if (period == 8'd0) state_d = START;
        else begin state_d = WAIT; timer_d = period - 8'd1; end
      end
      WAIT: begin
        if (!enable)              state_d = IDLE;
        else if (timer_q == 8'd0) state_d = START;
        else                      timer_d = timer_q - 8'd1;
      end
      START: begin
        state_d = CONV;
        tmo_d   = '0;
      end
      CONV: begin
        if (bus.sample_valid) begin
          acc_d  = acc_q + {3'b000, bus.sample};
          scnt_d = scnt_q + 4'd1;
          if (scnt_q + 4'd1 == (4'd1 << avg_q)) state_d = STORE;
          else if (!enable)                      state_d = IDLE;
          else if (period == 8'd0)               state_d = START;
          else begin state_d = WAIT; timer_d = period - 8'd1; end
        end else if (tmo_q == 6'd63) begin
          to_set  = 1'b1;
          acc_d   = '0;
          scnt_d  = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
      end
      STORE: begin
        acc_d  = '0;
        scnt_d = '0;
        if (!enable)             state_d = IDLE;
        else if (period == 8'd0) state_d = START;
        else begin state_d = WAIT; timer_d = period - 8'd1; end
      end
      default: state_d = IDLE;
    endcase
  end

  // Averaged result never exceeds 8 bits, so each shift picks an 8-bit window.
  always_comb begin
    unique case (avg_q)
      2'd0: result = acc_q[7:0];
      2'd1: result = acc_q[8:1];
      2'd2: result = acc_q[9:2];
      default: result = acc_q[10:3];
    endcase
  end

  assign do_rd  = bus.rd_req && (count != 5'd0);
  assign do_wr  = (state_q == STORE) && ((count != 5'd16) || do_rd);
  assign ov_set = (state_q == STORE) && (count == 5'd16) && !do_rd;

  always_ff @(posedge adc_clk) begin
    if (do_wr) mem[wptr] <= result;
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      bus.rd_ack  <= 1'b0;
      bus.rd_data <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      bus.rd_ack <= do_rd;
      if (do_rd) begin
        bus.rd_data <= mem[rptr];
        rptr        <= rptr + 4'd1;
      end
      if (do_wr) wptr <= wptr + 4'd1;
      count <= count + {4'd0, do_wr} - {4'd0, do_rd};
      // A set in the same cycle wins over the clear.
      if (ov_set)         overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (to_set)         timeout  <= 1'b1;
      else if (clr_flags) timeout  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl: averaging, FIFO full/overflow, same-cycle
// store+read, timeout, partial-average discard and reset mid-conversion.
module tb_adc_seq_ctrl;
  logic       adc_clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] period;
  logic [1:0] avg_sel;
  logic       clr_flags;
  logic [4:0] count;
  logic       overflow;
  logic       timeout;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  adc_seq_if ifc();

  adc_seq_ctrl dut (
    .adc_clk  (adc_clk),
    .reset    (reset),
    .enable   (enable),
    .period   (period),
    .avg_sel  (avg_sel),
    .clr_flags(clr_flags),
    .bus      (ifc),
    .count    (count),
    .overflow (overflow),
    .timeout  (timeout)
  );

  always #5 adc_clk = ~adc_clk;
  always @(posedge adc_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge adc_clk); #1;
  endtask

  // Waits (bounded) for a conversion request; returns the cycle it was seen.
  task automatic wait_conv(output int at);
    int n = 0;
    while (n < 300 && ifc.conv_start !== 1'b1) begin tick(); n++; end
    at = cyc;
    total++;
    if (ifc.conv_start !== 1'b1) begin
      bad++;
      $display("FAIL conv_start_wait: got no pulse within %0d cycles, want pulse", n);
    end
  endtask

  // Called in the START cycle; answers the request one cycle later in CONV.
  task automatic give_sample(input logic [7:0] s);
    tick();
    total++;
    if (ifc.conv_start !== 1'b0) begin
      bad++; $display("FAIL conv_start_width: got %b want 0", ifc.conv_start);
    end
    ifc.sample_valid = 1'b1;
    ifc.sample       = s;
    tick();
    ifc.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; period = '0; avg_sel = '0; clr_flags = 1'b0;
    ifc.sample_valid = 1'b0; ifc.sample = '0; ifc.rd_req = 1'b0;
    repeat (3) tick();
    total++;
    if ({ifc.conv_start, ifc.rd_ack, ifc.rd_data, count, overflow, timeout} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {ifc.conv_start, ifc.rd_ack, ifc.rd_data, count, overflow, timeout});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_average();
    int t[4];
    avg_sel = 2'd2; period = 8'd3; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_conv(t[i]);
      give_sample(8'(10 + i));
    end
    enable = 1'b0;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (t[i] - t[i-1] != 5) begin
        bad++; $display("FAIL conv_spacing%0d: got %0d want 5", i, t[i] - t[i-1]);
      end
    end
    tick();
    total++;
    if (count !== 5'd1) begin bad++; $display("FAIL avg_count: got %0d want 1", count); end
    ifc.rd_req = 1'b1;
    tick();
    ifc.rd_req = 1'b0;
    total++;
    if (ifc.rd_ack !== 1'b1 || ifc.rd_data !== 8'd11 || count !== 5'd0) begin
      bad++; $display("FAIL avg_read: got ack=%b data=%0d count=%0d want 1 11 0",
        ifc.rd_ack, ifc.rd_data, count);
    end
    tick();
    total++;
    if (ifc.rd_ack !== 1'b0) begin bad++; $display("FAIL ack_width: got %b want 0", ifc.rd_ack); end
  endtask

  task automatic test_overflow();
    int t;
    logic [7:0] exp [17];
    avg_sel = 2'd0; period = 8'd0; enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp[i] = 8'(8'h20 + 3 * i);
      wait_conv(t);
      give_sample(exp[i]);
    end
    enable = 1'b0;
    tick();
    total++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_full: got count=%0d ovf=%b want 16 1", count, overflow);
    end
    ifc.rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (ifc.rd_ack !== 1'b1 || ifc.rd_data !== exp[i]) begin
        bad++; $display("FAIL ovf_read%0d: got ack=%b data=%h want 1 %h", i, ifc.rd_ack, ifc.rd_data, exp[i]);
      end
    end
    tick();
    total++;
    if (ifc.rd_ack !== 1'b0 || ifc.rd_data !== exp[15] || count !== 5'd0) begin
      bad++; $display("FAIL empty_read: got ack=%b data=%h count=%0d want 0 %h 0",
        ifc.rd_ack, ifc.rd_data, count, exp[15]);
    end
    ifc.rd_req = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int t;
    avg_sel = 2'd0; period = 8'd0; enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_conv(t);
      give_sample(8'(8'h40 + i));
    end
    // Now in STORE with a full FIFO; read in the same cycle.
    ifc.rd_req = 1'b1;
    enable = 1'b0;
    tick();
    total++;
    if (ifc.rd_ack !== 1'b1 || ifc.rd_data !== 8'h40 || count !== 5'd16 || overflow !== 1'b0) begin
      bad++; $display("FAIL store_read: got ack=%b data=%h count=%0d ovf=%b want 1 40 16 0",
        ifc.rd_ack, ifc.rd_data, count, overflow);
    end
    for (int i = 1; i < 17; i++) begin
      tick();
      total++;
      if (ifc.rd_ack !== 1'b1 || ifc.rd_data !== 8'(8'h40 + i)) begin
        bad++; $display("FAIL b2b_read%0d: got ack=%b data=%h want 1 %h", i, ifc.rd_ack, ifc.rd_data, 8'(8'h40 + i));
      end
    end
    ifc.rd_req = 1'b0;
    tick();
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_timeout();
    int t;
    avg_sel = 2'd0; period = 8'd0; enable = 1'b1;
    wait_conv(t);
    enable = 1'b0;
    repeat (64) tick();
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout); end
    tick();
    total++;
    if (timeout !== 1'b1 || dut.state_q !== 3'd0 || count !== 5'd0) begin
      bad++; $display("FAIL timeout_set: got to=%b state=%0d count=%0d want 1 0 0",
        timeout, dut.state_q, count);
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout); end
  endtask

  task automatic test_partial();
    int t;
    avg_sel = 2'd3; period = 8'd1; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_conv(t);
      give_sample(8'd100);
    end
    enable = 1'b0;
    repeat (3) tick();
    total++;
    if (dut.state_q !== 3'd0 || count !== 5'd0) begin
      bad++; $display("FAIL partial_drop: got state=%0d count=%0d want 0 0", dut.state_q, count);
    end
    avg_sel = 2'd0; enable = 1'b1;
    wait_conv(t);
    give_sample(8'd50);
    enable = 1'b0;
    tick();
    ifc.rd_req = 1'b1;
    tick();
    ifc.rd_req = 1'b0;
    total++;
    if (ifc.rd_ack !== 1'b1 || ifc.rd_data !== 8'd50) begin
      bad++; $display("FAIL partial_fresh: got ack=%b data=%0d want 1 50", ifc.rd_ack, ifc.rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int t;
    avg_sel = 2'd0; period = 8'd0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_conv(t);
      give_sample(8'(i + 1));
    end
    wait_conv(t);
    tick();
    total++;
    if (count !== 5'd4 || dut.state_q !== 3'd3) begin
      bad++; $display("FAIL mid_pre: got count=%0d state=%0d want 4 3", count, dut.state_q);
    end
    #2 reset = 1'b1;
    ifc.sample_valid = 1'b1; ifc.sample = 8'd99;
    #1;
    total++;
    if ({ifc.conv_start, ifc.rd_ack, ifc.rd_data, count, overflow, timeout} !== 17'd0) begin
      bad++; $display("FAIL mid_reset: got %h want 0",
        {ifc.conv_start, ifc.rd_ack, ifc.rd_data, count, overflow, timeout});
    end
    tick();
    enable = 1'b0; ifc.sample_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    total++;
    if (count !== 5'd0 || ifc.rd_ack !== 1'b0 || dut.state_q !== 3'd0) begin
      bad++; $display("FAIL mid_after: got count=%0d ack=%b state=%0d want 0 0 0",
        count, ifc.rd_ack, dut.state_q);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_partial();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 SHALL have port adc_clk  in  1  sampling clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset; clock adc_clk.
REQ-003 SHALL have port enable  in  1  run request for the conversion sequencer.
REQ-004 SHALL have port period  in  8  number of idle cycles between conversion requests.
REQ-005 SHALL have port avg_sel  in  2  averaging depth; 2^avg_sel samples per stored result.
REQ-006 SHALL have port clr_flags  in  1  synchronous clear of sticky flags.
REQ-007 SHALL have port conv_start  out  1  one-cycle pulse requesting one conversion from the capture engine.
REQ-008 SHALL have port sample_valid  in  1  one-cycle pulse from the capture engine marking sample as valid.
REQ-009 SHALL have port sample  in  8  converted sample value.
REQ-010 SHALL have port rd_req  in  1  host read request, level, held until acknowledged.
REQ-011 SHALL have port rd_ack  out  1  one-cycle pulse marking rd_data as valid.
REQ-012 SHALL have port rd_data  out  8  oldest stored averaged result.
REQ-013 SHALL have port count  out  5  number of results held, 0..16.
REQ-014 SHALL have port overflow  out  1  sticky flag: a result was dropped because the buffer was full.
REQ-015 SHALL have port timeout  out  1  sticky flag: a conversion received no sample_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, START, CONV, STORE.
REQ-017 SHALL, in IDLE with enable=1, latch avg_sel, clear accumulator and sample counter, then go to START if period=0, else to WAIT with timer=period-1.
REQ-018 SHALL make WAIT last exactly period cycles, going to START when timer=0; enable=0 in WAIT goes to IDLE.
REQ-019 SHALL drive conv_start=1 for exactly the single cycle spent in START, then enter CONV.
REQ-020 SHALL, in CONV on sample_valid, add sample to an 11-bit accumulator and increment the sample counter.
REQ-021 After that sample, SHALL go to STORE if the sample counter reaches 2^avg_sel; otherwise SHALL go to IDLE if enable=0, else reload period as in REQ-017.
REQ-022 SHALL, if 64 cycles elapse in CONV without sample_valid, set timeout, discard the accumulation, and go to IDLE.
REQ-023 SHALL ignore sample_valid outside CONV.
REQ-024 SHALL, in STORE, compute result = accumulator >> avg_sel (truncating, 8 bits) and write it to a 16-entry FIFO.
REQ-025 After STORE, SHALL clear the accumulator and counter, then go to IDLE if enable=0, else reload period as in REQ-017.
REQ-026 SHALL discard a partial average when enable falls; no partial result is ever stored.
REQ-027 SHALL, when the FIFO is full in STORE with no read that cycle, drop the result, set overflow, and leave count unchanged.
REQ-028 SHALL handle a read: rd_req=1 and count>0 at edge N gives rd_ack=1 and rd_data=oldest entry for the cycle after N, and count decrements.
REQ-029 SHALL give no rd_ack for rd_req with count=0; rd_data holds its last value.
REQ-030 SHALL accept a held rd_req as one read per cycle while count>0.
REQ-031 SHALL, on a same-cycle STORE write and read, perform both, leave count unchanged, and not set overflow even when full.
REQ-032 SHALL wrap the read and write pointers modulo 16; count SHALL never exceed 16.
REQ-033 SHALL make clr_flags=1 clear overflow and timeout next edge, with a same-cycle set taking priority.

Reset
REQ-034 SHALL, on reset, force state IDLE with conv_start=0, rd_ack=0, rd_data=0, count=0, overflow=0, timeout=0, and clear the pointers, accumulator, and counters.
REQ-035 SHALL treat reset mid-conversion or mid-read as abandoning the operation: no rd_ack and no FIFO write afterwards.

Verification
REQ-036 SHALL cover: avg_sel=2, period=3, samples 10,11,12,13 -> one entry 11, count=1; conv_start pulses separated by 3 WAIT cycles plus CONV time.
REQ-037 SHALL cover: avg_sel=0, 17 samples, no reads -> count=16, overflow=1; the 16 reads return the first 16 samples in order.
REQ-038 SHALL cover: full FIFO, STORE coinciding with rd_req -> rd_ack, count stays 16, overflow stays 0.
REQ-039 SHALL cover: no sample_valid for 64 cycles after conv_start -> timeout=1, FSM in IDLE; clr_flags -> timeout=0.
REQ-040 SHALL cover: avg_sel=3, enable dropped after 5 samples -> FSM in IDLE, count unchanged, no entry written.
REQ-041 SHALL cover: reset asserted in CONV with count=4 -> all outputs at reset values at once, count=0.
